dram_arbiter: RTL

DRAM_ARBITER -- requirements
Module: dram_arbiter

---
 rtl/dram_arbiter.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/dram_arbiter.sv
// Two-core arbiter for a single-port synchronous DRAM. Round-robin on ties,
// with a hold limit that forces hand-over when both cores keep requesting.
//
// state | meaning
// IDLE  | no owner; DRAM address/data hold their last driven values
// OWN1  | core1 granted; an access is issued whenever req1 is high
// OWN2  | core2 granted; an access is issued whenever req2 is high
module dram_arbiter #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic              CLK,
   input  logic              rst_n,
   input  logic              req1,
   input  logic              req2,
   input  logic              we1,
   input  logic              we2,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [ADDR_W-1:0] addr2,
   input  logic [DATA_W-1:0] wdata1,
   input  logic [DATA_W-1:0] wdata2,
   output logic              gnt1,
   output logic              gnt2,
   output logic              rvalid1,
   output logic              rvalid2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q
);

   typedef enum logic [1:0] {IDLE, OWN1, OWN2} state_t;

   localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD - 1);

   state_t            state;
   logic [3:0]        hold;
   logic              last2;
   logic              acc1;
   logic              acc2;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata1_q;
   logic [DATA_W-1:0] rdata2_q;

   assign acc1     = gnt1 & req1;
   assign acc2     = gnt2 & req2;
   assign mem_wren = (acc1 & we1) | (acc2 & we2);

   always_comb begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      if (gnt1) begin
         mem_addr  = addr1;
         mem_wdata = wdata1;
      end else if (gnt2) begin
         mem_addr  = addr2;
         mem_wdata = wdata2;
      end
   end

   // mem_q is only valid during the return cycle, so pass it through then and hold afterwards
   assign rdata1 = rvalid1 ? mem_q : rdata1_q;
   assign rdata2 = rvalid2 ? mem_q : rdata2_q;

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt1     <= 1'b0;
         gnt2     <= 1'b0;
         hold     <= '0;
         last2    <= 1'b1;
         rvalid1  <= 1'b0;
         rvalid2  <= 1'b0;
         rdata1_q <= '0;
         rdata2_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         rvalid1 <= acc1 & ~we1;
         rvalid2 <= acc2 & ~we2;
         if (rvalid1) rdata1_q <= mem_q;
         if (rvalid2) rdata2_q <= mem_q;
         if (state != IDLE) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
         end

         case (state)
            IDLE: begin
               hold <= '0;
               if (req1 && (!req2 || last2)) begin
                  state <= OWN1;
                  gnt1  <= 1'b1;
                  gnt2  <= 1'b0;
                  last2 <= 1'b0;
               end else if (req2) begin
                  state <= OWN2;
                  gnt1  <= 1'b0;
                  gnt2  <= 1'b1;
                  last2 <= 1'b1;
               end
            end
            OWN1: begin
               if (!req1 || (req2 && hold == HOLD_MAX)) begin
                  hold <= '0;
                  gnt1 <= 1'b0;
                  if (req2) begin
                     state <= OWN2;
                     gnt2  <= 1'b1;
                     last2 <= 1'b1;
                  end else begin
                     state <= IDLE;
                     gnt2  <= 1'b0;
                  end
               end else if (hold != HOLD_MAX) begin
                  hold <= hold + 4'd1;
               end
            end
            OWN2: begin
               if (!req2 || (req1 && hold == HOLD_MAX)) begin
                  hold <= '0;
                  gnt2 <= 1'b0;
                  if (req1) begin
                     state <= OWN1;
                     gnt1  <= 1'b1;
                     last2 <= 1'b0;
                  end else begin
                     state <= IDLE;
                     gnt1  <= 1'b0;
                  end
               end else if (hold != HOLD_MAX) begin
                  hold <= hold + 4'd1;
               end
            end
            default: begin
               state <= IDLE;
               gnt1  <= 1'b0;
               gnt2  <= 1'b0;
               hold  <= '0;
            end
         endcase
      end
   end

endmodule
